// File: rtl/reg_status_bank.sv
// reg_status_bank: register bank with Tomasulo producer tags.
// Each register holds a value and a producer tag (0 = value ready).
// Issue renames destinations and the CDB retires results by tag match.
// Operand reads return the state from before the current edge's updates.
// base_data and pending return the state after the current edge's updates.
// Optional feature: define REGBANK_CDB_BYPASS_EN to forward a matching
// same-cycle CDB result onto the operand read ports.
module reg_status_bank #(
  parameter int DATA_W   = 8,
  parameter int NREG     = 4,
  parameter int ADDR_W   = 2,
  parameter int TAG_W    = 3,
  parameter int BASE_REG = NREG - 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  output logic [TAG_W-1:0]  rd1_tag,
  output logic [TAG_W-1:0]  rd2_tag,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [DATA_W-1:0] base_data,
  output logic [NREG-1:0]   pending,
  output logic              err
);

  logic [DATA_W-1:0] val_q [NREG];
  logic [DATA_W-1:0] val_d [NREG];
  logic [TAG_W-1:0]  tag_q [NREG];
  logic [TAG_W-1:0]  tag_d [NREG];

  logic [DATA_W-1:0] rd1_data_q, rd1_data_d, rd2_data_q, rd2_data_d;
  logic [TAG_W-1:0]  rd1_tag_q, rd1_tag_d, rd2_tag_q, rd2_tag_d;
  logic [DATA_W-1:0] base_data_q, base_data_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              err_q, err_d;

  logic cdb_hit_ok;
  logic issue_ok;

  // Next-state: CDB write-back first, then rename overrides the tag.
  always_comb begin
    cdb_hit_ok = cdb_valid && (cdb_tag != '0);
    issue_ok   = issue_en && (issue_tag != '0);
    for (int i = 0; i < NREG; i++) begin
      val_d[i] = val_q[i];
      tag_d[i] = tag_q[i];
      if (cdb_hit_ok && (tag_q[i] == cdb_tag)) begin
        val_d[i] = cdb_data;
        tag_d[i] = '0;
      end
      if (issue_ok && (issue_reg == ADDR_W'(i))) begin
        tag_d[i] = issue_tag;
      end
    end
    err_d = err_q || (cdb_valid && (cdb_tag == '0)) || (issue_en && (issue_tag == '0));
    base_data_d = val_d[BASE_REG];
    for (int i = 0; i < NREG; i++) begin
      pending_d[i] = (tag_d[i] != '0);
    end
  end

  // Operand reads from pre-update state, with optional same-cycle CDB forward.
  always_comb begin
    rd1_data_d = val_q[rd1_addr];
    rd1_tag_d  = tag_q[rd1_addr];
    rd2_data_d = val_q[rd2_addr];
    rd2_tag_d  = tag_q[rd2_addr];
`ifdef REGBANK_CDB_BYPASS_EN
    if (cdb_valid && (tag_q[rd1_addr] != '0) && (tag_q[rd1_addr] == cdb_tag)) begin
      rd1_data_d = cdb_data;
      rd1_tag_d  = '0;
    end
    if (cdb_valid && (tag_q[rd2_addr] != '0) && (tag_q[rd2_addr] == cdb_tag)) begin
      rd2_data_d = cdb_data;
      rd2_tag_d  = '0;
    end
`else
`endif
  end

  // State and output registers; asynchronous reset clears everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      rd1_data_q  <= '0;
      rd1_tag_q   <= '0;
      rd2_data_q  <= '0;
      rd2_tag_q   <= '0;
      base_data_q <= '0;
      pending_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
      rd1_data_q  <= rd1_data_d;
      rd1_tag_q   <= rd1_tag_d;
      rd2_data_q  <= rd2_data_d;
      rd2_tag_q   <= rd2_tag_d;
      base_data_q <= base_data_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
    end
  end

  assign rd1_data  = rd1_data_q;
  assign rd1_tag   = rd1_tag_q;
  assign rd2_data  = rd2_data_q;
  assign rd2_tag   = rd2_tag_q;
  assign base_data = base_data_q;
  assign pending   = pending_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_status_bank.sv
// Directed testbench for reg_status_bank (default parameters).
module tb_reg_status_bank;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] rd1_addr = '0, rd2_addr = '0;
  logic [7:0] rd1_data, rd2_data;
  logic [2:0] rd1_tag, rd2_tag;
  logic       issue_en = 1'b0;
  logic [1:0] issue_reg = '0;
  logic [2:0] issue_tag = '0;
  logic       cdb_valid = 1'b0;
  logic [2:0] cdb_tag = '0;
  logic [7:0] cdb_data = '0;
  logic [7:0] base_data;
  logic [3:0] pending;
  logic       err;

  int n_cmp = 0;
  int n_mis = 0;

  reg_status_bank dut (
    .clock(clock), .reset(reset),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .rd1_tag(rd1_tag), .rd2_tag(rd2_tag),
    .issue_en(issue_en), .issue_reg(issue_reg), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .base_data(base_data), .pending(pending), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_en  = 1'b0;
    issue_tag = '0;
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_data  = '0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_rd1_data", rd1_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err", err, 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Rename R2 with tag 5; same-cycle read of R2 sees pre-rename tag
    rd1_addr = 2; issue_en = 1; issue_reg = 2; issue_tag = 5;
    tick();
    chk("ren_same_cycle_tag", rd1_tag, 0);
    chk("ren_pending", pending, 4'b0100);
    idle();
    tick();
    chk("ren_rd1_tag", rd1_tag, 5);
    chk("ren_rd1_data", rd1_data, 0);

    // CDB multi-match: R1 and R3 both tagged 3
    issue_en = 1; issue_reg = 1; issue_tag = 3;
    tick();
    issue_reg = 3;
    tick();
    chk("mm_pending_before", pending, 4'b1110);
    idle();
    cdb_valid = 1; cdb_tag = 3; cdb_data = 8'hA5;
    tick();
    chk("mm_pending_after", pending, 4'b0100);
    chk("mm_base_data", base_data, 8'hA5);
    idle();
    rd1_addr = 1; rd2_addr = 3;
    tick();
    chk("mm_r1_data", rd1_data, 8'hA5);
    chk("mm_r1_tag", rd1_tag, 0);
    chk("mm_r3_data", rd2_data, 8'hA5);
    chk("mm_r3_tag", rd2_tag, 0);
    cdb_valid = 1; cdb_tag = 5; cdb_data = 8'h11;
    tick();
    chk("r2_resolve_pending", pending, 0);
    idle();

    // Same-edge issue + CDB on R0
    issue_en = 1; issue_reg = 0; issue_tag = 2;
    tick();
    issue_tag = 6; cdb_valid = 1; cdb_tag = 2; cdb_data = 8'h3C;
    tick();
    chk("same_pending", pending, 4'b0001);
    idle();
    rd1_addr = 0; rd2_addr = 0;
    tick();
    chk("same_r0_data", rd1_data, 8'h3C);
    chk("same_r0_tag", rd1_tag, 6);
    chk("dual_port_data", rd2_data, 8'h3C);
    chk("dual_port_tag", rd2_tag, 6);
    chk("same_base_data", base_data, 8'hA5);

    // CDB vs. same-cycle read of R1
    issue_en = 1; issue_reg = 1; issue_tag = 4;
    tick();
    idle();
    rd1_addr = 1; cdb_valid = 1; cdb_tag = 4; cdb_data = 8'h77;
    tick();
`ifdef REGBANK_CDB_BYPASS_EN
    chk("byp_rd1_data", rd1_data, 8'h77);
    chk("byp_rd1_tag", rd1_tag, 0);
`else
    chk("nobyp_rd1_data", rd1_data, 8'hA5);
    chk("nobyp_rd1_tag", rd1_tag, 4);
`endif
    idle();
    tick();
    chk("byp_next_data", rd1_data, 8'h77);
    chk("byp_next_tag", rd1_tag, 0);
    chk("byp_pending", pending, 4'b0001);

    // Illegal issue tag
    chk("pre_ill_err", err, 0);
    issue_en = 1; issue_reg = 2; issue_tag = 0;
    tick();
    chk("ill_err", err, 1);
    chk("ill_pending", pending, 4'b0001);
    idle();
    rd1_addr = 2;
    tick();
    chk("ill_r2_tag", rd1_tag, 0);
    chk("ill_r2_data", rd1_data, 8'h11);
    tick(); tick();
    chk("ill_err_sticky", err, 1);

    // Asynchronous reset mid-cycle
    #3;
    reset = 1'b0;
    #1;
    chk("arst_rd1_data", rd1_data, 0);
    chk("arst_pending", pending, 0);
    chk("arst_base", base_data, 0);
    chk("arst_err", err, 0);
    @(negedge clock);
    reset = 1'b1;
    rd1_addr = 0;
    tick();
    chk("post_rst_r0_tag", rd1_tag, 0);
    chk("post_rst_r0_data", rd1_data, 0);

    // CDB with tag 0 flags error and changes nothing
    cdb_valid = 1; cdb_tag = 0; cdb_data = 8'hFF;
    tick();
    chk("cdb0_err", err, 1);
    idle();
    tick();
    chk("cdb0_r0_data", rd1_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
